// File: rtl/vga_capture.sv
// vga_capture: VGA sync recovery and grayscale frame grabber writing one byte per active pixel
module vga_capture #(
    parameter int H_TOTAL  = 800,
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic        cap_en,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    output logic        wr_en,
    output logic [18:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err
);
    localparam logic [9:0]  H_MAX  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  H_LO   = 10'(H_START);
    localparam logic [9:0]  H_HI   = 10'(H_START + H_ACTIVE);
    localparam logic [9:0]  V_LO   = 10'(V_START);
    localparam logic [9:0]  V_HI   = 10'(V_START + V_ACTIVE);
    localparam logic [18:0] A_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t      st_q, st_d;
    logic        hs_q, hs_d, hs_p_q, hs_p_d, vs_q, vs_d, vs_p_q, vs_p_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic        ph_q, ph_d, pend_q, pend_d;
    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [18:0] a_q, a_d;
    logic        wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [18:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        hs_fall, vs_fall, active, last, wr;

    always_comb begin
        hs_d   = hs_in;
        vs_d   = vs_in;
        hs_p_d = hs_q;
        vs_p_d = vs_q;
        r_d    = r_in;
        g_d    = g_in;
        b_d    = b_in;
        hs_fall = ~hs_q & hs_p_q;
        vs_fall = ~vs_q & vs_p_q;
        ph_d = ~hs_fall & ~ph_q;
        h_d  = hs_fall ? '0 : (ph_q && h_q != H_MAX) ? h_q + 10'd1 : h_q;
        v_d  = vs_fall ? '0 : (hs_fall && v_q != 10'h3ff) ? v_q + 10'd1 : v_q;
        active = ph_q && h_q >= H_LO && h_q < H_HI && v_q >= V_LO && v_q < V_HI;
        last   = a_q == A_LAST;
        wr     = 1'b0;
        st_d   = st_q;
        a_d    = a_q;
        pend_d = 1'b0;
        err_d  = 1'b0;
        done_d = 1'b0;
        case (st_q)
            IDLE: begin
                if (vs_fall && cap_en) begin
                    st_d = CAPTURE;
                    a_d  = '0;
                end
            end
            CAPTURE: begin
                // a sync edge landing on the final write re-arms the next frame via DONE
                if (active && last) begin
                    wr     = 1'b1;
                    st_d   = DONE;
                    pend_d = vs_fall && cap_en;
                end else if (vs_fall) begin
                    err_d = 1'b1;
                    a_d   = '0;
                    st_d  = cap_en ? CAPTURE : IDLE;
                end else if (active) begin
                    wr  = 1'b1;
                    a_d = a_q + 19'd1;
                end
            end
            DONE: begin
                done_d = 1'b1;
                a_d    = '0;
                st_d   = (pend_q || (vs_fall && cap_en)) ? CAPTURE : IDLE;
            end
            default: st_d = IDLE;
        endcase
        wr_en_d   = wr;
        wr_addr_d = wr ? a_q : wr_addr_q;
        wr_data_d = wr ? 8'(({2'b0, r_q} + {1'b0, g_q, 1'b0} + {2'b0, b_q}) >> 2) : wr_data_q;
        busy_d    = st_d != IDLE;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= IDLE;
            hs_q      <= 1'b1;
            hs_p_q    <= 1'b1;
            vs_q      <= 1'b1;
            vs_p_q    <= 1'b1;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            ph_q      <= 1'b0;
            pend_q    <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            a_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            hs_q      <= hs_d;
            hs_p_q    <= hs_p_d;
            vs_q      <= vs_d;
            vs_p_q    <= vs_p_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            ph_q      <= ph_d;
            pend_q    <= pend_d;
            h_q       <= h_d;
            v_q       <= v_d;
            a_q       <= a_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
endmodule

// File: doc/vga_capture.md
# vga_capture

Frame grabber for the receiving end of the 640x480 VGA link: samples hs, vs and 24-bit RGB on the system clock, recovers pixel and line position from the sync edges, and writes one 8-bit grayscale byte per active pixel into a 307200-byte frame buffer through a simple write port. It sits between the external video input and the frame RAM that the display driver later reads back.

## Interface
- H_TOTAL, 800, pixel clocks per line
- H_START, 144, pixel clocks from hs falling edge to first active pixel
- H_ACTIVE, 640, active pixels per line
- V_START, 35, hs falling edges from vs falling edge to first active line
- V_ACTIVE, 480, active lines per frame
- clk_50  in  1  50 MHz system clock; pixel rate is clk_50/2
- rst_n  in  1  asynchronous active-low reset
- cap_en  in  1  allow new frames to start
- hs_in  in  1  horizontal sync, active low
- vs_in  in  1  vertical sync, active low
- r_in, g_in, b_in  in  8 each  pixel colour
- wr_en  out  1  frame-buffer write strobe, one cycle
- wr_addr  out  19  byte address, line*640+pixel
- wr_data  out  8  grayscale pixel
- busy  out  1  frame capture in progress
- frame_done  out  1  one-cycle pulse after the last write of a frame
- frame_err  out  1  one-cycle pulse on an aborted frame

## Operation
- Input stage: hs_in, vs_in, r/g/b registered once. Falling edge = registered value 0, previous registered value 1.
- Pixel phase: 1-bit toggle, cleared on hs falling edge. h_cnt (10 bit) cleared on hs falling edge, increments when phase goes 1->0; saturates at H_TOTAL-1.
- v_cnt (10 bit): cleared on vs falling edge, increments on each hs falling edge, saturates at 1023.
- Active pixel: phase==1, H_START <= h_cnt < H_START+H_ACTIVE, V_START <= v_cnt < V_START+V_ACTIVE. Sample taken from the registered RGB at that cycle.
- Grayscale: wr_data = (r + 2*g + b) >> 2, 10-bit sum, never overflows (max 1020 -> 255).
- FSM states:
  - IDLE: no writes. Moves to CAPTURE on a vs falling edge while cap_en==1; wr_addr counter cleared to 0.
  - CAPTURE: busy=1, one write per active pixel, address +1 per write. After write 307199 -> DONE.
  - DONE: frame_done=1 for one cycle -> IDLE.
- cap_en deasserted during CAPTURE: current frame completes; only the start of the next frame is blocked.
- vs falling edge in CAPTURE before write 307199: frame_err pulses, address restarts at 0, stays in CAPTURE if cap_en==1, else goes to IDLE.
- vs falling edge in the same cycle as the last write: last write completes, frame_done pulses, the new edge is treated as a frame start in IDLE (counter re-armed, no err).
- Address never exceeds 307199; no wrap inside a frame.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, frame_err=0, FSM=IDLE, counters 0, sync history registers 1.
- Latency: RGB at the pin -> wr_en/wr_data/wr_addr valid 2 clk_50 cycles later (input reg + output reg). All outputs registered.
- Writes come every 2 cycles within a line, 640 per line, never back-to-back.
- frame_done rises the cycle after the final wr_en. frame_err rises 2 cycles after the offending vs pin edge.
- busy rises 2 cycles after the starting vs pin edge and falls with frame_done.
- rst_n low at any point: all outputs return to reset values immediately; after release, capture waits for the next vs falling edge.

## Test plan
- Reset then idle syncs with cap_en=0 -> no wr_en, busy=0, all outputs 0.
- cap_en=1, one full 800x525 frame at clk_50/2 with r=g=b=pixel index mod 256 -> exactly 307200 writes, addresses 0..307199 in order, wr_data equals the pixel index mod 256, one frame_done pulse.
- Colour check: r=255,g=0,b=0 -> 63; r=0,g=255,b=0 -> 127; r=g=b=255 -> 255.
- vs re-asserted after 100 active lines -> frame_err one cycle, next write at address 0, full frame then completes with frame_done.
- cap_en dropped at line 200 -> frame finishes (307200 writes, frame_done), next vs ignored, busy stays 0.
- rst_n pulsed at line 300 -> outputs zero asynchronously; the following full frame captures normally from address 0.
